// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART TX byte stream. A grant is held until
// the packet ends, MAX_PKT bytes have gone out, or the holder stalls for IDLE_TMO cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_PKT  = 64,
    parameter int IDLE_TMO = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_grant_id;
    logic [1:0] r_last_grant;
    logic [7:0] r_byte_cnt;
    logic [7:0] r_stall_cnt;

    logic       w_win_found;
    logic [1:0] w_winner;
    logic       w_sel_valid;
    logic       w_sel_last;
    logic [7:0] w_sel_data;
    logic       w_lock;
    logic       w_xfer;
    logic       w_stall;
    logic       w_exit;

    // Selected requester lane
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == 2'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Offsets 1..NUM_REQ from last_grant in priority order; the first valid one wins
    always_comb begin
        w_win_found = 1'b0;
        w_winner    = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_win_found && req_valid[i] &&
                    ((int'(r_last_grant) + k) % NUM_REQ) == i) begin
                    w_win_found = 1'b1;
                    w_winner    = 2'(i);
                end
            end
        end
    end

    assign w_lock  = (r_state == ST_LOCK);
    assign w_xfer  = w_lock && w_sel_valid && out_ready;
    assign w_stall = w_lock && !w_sel_valid;
    assign w_exit  = (w_xfer && (w_sel_last || (r_byte_cnt + 8'd1) == 8'(MAX_PKT))) ||
                     (w_stall && (r_stall_cnt + 8'd1) >= 8'(IDLE_TMO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_win_found) w_next = ST_LOCK;
            ST_LOCK: if (w_exit)      w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = w_lock;
        grant_id  = r_grant_id;
        if (w_lock) begin
            out_valid = w_sel_valid;
            out_data  = w_sel_data;
            for (int i = 0; i < NUM_REQ; i++)
                req_ready[i] = (r_grant_id == 2'(i)) && out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= 2'd0;
            r_last_grant <= 2'(NUM_REQ - 1);
            r_byte_cnt   <= 8'd0;
            r_stall_cnt  <= 8'd0;
        end else if (!w_lock) begin
            if (w_win_found) begin
                r_grant_id  <= w_winner;
                r_byte_cnt  <= 8'd0;
                r_stall_cnt <= 8'd0;
            end
        end else begin
            if (w_xfer) begin
                r_byte_cnt  <= r_byte_cnt + 8'd1;
                r_stall_cnt <= 8'd0;
            end else if (w_stall && r_stall_cnt != 8'hFF) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_exit) r_last_grant <= r_grant_id;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences, and random
// packet traffic checked every cycle against a grant-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 3;
    localparam int MAX = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           out_valid, out_ready;
    logic [7:0]     out_data;
    logic [1:0]     grant_id;
    logic           busy;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT(MAX), .IDLE_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: who owns the line, who owned it last, bytes and stalls this grant
    int m_owner, m_prev, m_sent, m_stall;

    bit         src_mode, rnd_gaps, rnd_ordy;
    logic [8:0] srcq [N][$];
    int         pause [N];
    int         obs[$];
    int         e36[$];
    int         cyc, bad, n;
    logic [2:0] hist [20];

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic       ordy;
        logic       eb;
        logic [1:0] eg;
        logic       eov;
        logic [2:0] er;
        logic [7:0] ed;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_prev  = N - 1;
        m_sent  = 0;
        m_stall = 0;
    endtask

    task automatic model_cmp();
        if (m_owner < 0) begin
            chk("m_busy", 32'(busy), 0);
            chk("m_ovalid", 32'(out_valid), 0);
            chk("m_ready", 32'(req_ready), 0);
        end else begin
            chk("m_busy", 32'(busy), 1);
            chk("m_gid", 32'(grant_id), m_owner);
            chk("m_ovalid", 32'(out_valid), 32'(req_valid[m_owner]));
            chk("m_ready", 32'(req_ready), 32'(out_ready) << m_owner);
            if (req_valid[m_owner]) chk("m_data", 32'(out_data), 32'(req_data[8*m_owner +: 8]));
        end
    endtask

    task automatic model_step();
        bit done;
        bit found;
        done = 1'b0;
        found = 1'b0;
        if (!rst_n) begin
            m_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (!found && req_valid[(m_prev + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_prev + k) % N;
                    m_sent  = 0;
                    m_stall = 0;
                end
            end
        end else begin
            if (req_valid[m_owner] && out_ready) begin
                m_sent++;
                m_stall = 0;
                done = req_last[m_owner] || (m_sent == MAX);
            end else if (!req_valid[m_owner]) begin
                m_stall++;
                done = (m_stall >= TMO);
            end
            if (done) begin
                m_prev  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic drive_srcs();
        bit go;
        for (int i = 0; i < N; i++) begin
            if (pause[i] > 0) pause[i]--;
            else if (rnd_gaps && $urandom_range(39) == 0) pause[i] = $urandom_range(25, 12);
            go = (srcq[i].size() > 0) && (pause[i] == 0) && (!rnd_gaps || $urandom_range(5) != 0);
            req_valid[i]      = go;
            req_last[i]       = go ? srcq[i][0][8] : 1'b0;
            req_data[8*i +: 8] = go ? srcq[i][0][7:0] : 8'($urandom);
        end
        if (rnd_ordy) out_ready = ($urandom_range(3) != 0);
    endtask

    // One clock: check outputs against the model mid-cycle, retire handshakes, advance
    task automatic tick();
        @(negedge clk);
        model_cmp();
        if (src_mode) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    chk("sb_data", 32'(out_data), 32'(srcq[i][0][7:0]));
                    obs.push_back(i * 256 + int'(out_data));
                    void'(srcq[i].pop_front());
                end
            end
        end
        model_step();
        @(posedge clk);
        #1;
        if (src_mode) drive_srcs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        src_mode = 1'b0; rnd_gaps = 1'b0; rnd_ordy = 1'b0;
        for (int i = 0; i < N; i++) begin
            pause[i] = 0;
            srcq[i].delete();
        end
        m_reset();
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_gid", 32'(grant_id), 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          v       l       rdy   busy  gid   ov    ready   data
        vt[0]  = '{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        vt[1]  = '{3'b010, 3'b010, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        vt[2]  = '{3'b010, 3'b010, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010, 8'hB1};
        vt[3]  = '{3'b011, 3'b011, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        vt[4]  = '{3'b011, 3'b011, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001, 8'hA0};
        vt[5]  = '{3'b011, 3'b011, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        vt[6]  = '{3'b011, 3'b011, 1'b0, 1'b1, 2'd1, 1'b1, 3'b000, 8'hB1};
        vt[7]  = '{3'b001, 3'b001, 1'b1, 1'b1, 2'd1, 1'b0, 3'b010, 8'h00};
        vt[8]  = '{3'b011, 3'b011, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010, 8'hB1};
        vt[9]  = '{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        vt[10] = '{3'b100, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        vt[11] = '{3'b100, 3'b000, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100, 8'hC2};
        vt[12] = '{3'b000, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 3'b100, 8'h00};

        do_reset();
        req_data = {8'hC2, 8'hB1, 8'hA0};
        for (int r = 0; r < 13; r++) begin
            req_valid = vt[r].v;
            req_last  = vt[r].l;
            out_ready = vt[r].ordy;
            #2;
            chk("vec_busy", 32'(busy), 32'(vt[r].eb));
            chk("vec_ovalid", 32'(out_valid), 32'(vt[r].eov));
            chk("vec_ready", 32'(req_ready), 32'(vt[r].er));
            if (vt[r].eb) chk("vec_gid", 32'(grant_id), 32'(vt[r].eg));
            if (vt[r].eov) chk("vec_data", 32'(out_data), 32'(vt[r].ed));
            tick();
        end

        // 3-byte packet from req0 with the line always ready
        do_reset();
        out_ready = 1'b1;
        req_valid = 3'b001;
        req_data  = 24'h000041;
        #2;
        chk("s34_idle", 32'(busy), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            req_data[7:0] = 8'h41 + 8'(k);
            req_last      = (k == 2) ? 3'b001 : 3'b000;
            #2;
            chk("s34_busy", 32'(busy), 1);
            chk("s34_gid", 32'(grant_id), 0);
            chk("s34_data", 32'(out_data), 32'h41 + 32'(k));
            chk("s34_ready", 32'(req_ready), 32'b001);
            tick();
        end
        req_valid = 3'b000;
        req_last  = 3'b000;
        #2;
        chk("s34_done", 32'(busy), 0);

        // Three requesters with 1-byte packets rotate 0,1,2,0,1,2
        do_reset();
        out_ready = 1'b1;
        req_valid = 3'b111;
        req_last  = 3'b111;
        req_data  = {8'hC2, 8'hB1, 8'hA0};
        for (int c = 0; c < 12; c++) begin
            #2;
            if (c % 2 == 0) begin
                chk("s35_gap", 32'(busy), 0);
            end else begin
                chk("s35_busy", 32'(busy), 1);
                chk("s35_gid", 32'(grant_id), (c / 2) % 3);
            end
            tick();
        end

        // req1 streams 10 bytes without last; MAX_PKT splits it around req2
        do_reset();
        out_ready = 1'b1;
        obs.delete();
        for (int k = 0; k < 10; k++) srcq[1].push_back({1'b0, 8'h10 + 8'(k)});
        srcq[2].push_back({1'b1, 8'hC2});
        src_mode = 1'b1;
        drive_srcs();
        for (int c = 0; c < 60; c++) tick();
        src_mode = 1'b0;
        e36.delete();
        for (int k = 0; k < 4; k++) e36.push_back(256 + 16 + k);
        e36.push_back(512 + 'hC2);
        for (int k = 4; k < 10; k++) e36.push_back(256 + 16 + k);
        chk("s36_count", obs.size(), e36.size());
        for (int k = 0; k < e36.size() && k < obs.size(); k++) chk("s36_order", obs[k], e36[k]);

        // Holder drops valid; released after 16 stalled cycles, req1 takes over
        do_reset();
        out_ready = 1'b1;
        req_valid = 3'b011;
        req_data  = {8'hC2, 8'hB1, 8'hA0};
        #2;
        chk("s37_idle", 32'(busy), 0);
        tick();
        req_valid = 3'b010;
        for (int c = 0; c < 20; c++) begin
            #2;
            hist[c] = {busy, grant_id};
            tick();
        end
        n = 0;
        while (n < 20 && hist[n] == 3'b100) n++;
        chk("s37_stall_len", n, 16);
        chk("s37_gap", 32'(hist[16][2]), 0);
        chk("s37_next", 32'(hist[17]), 32'b101);

        // Back-pressure for 20 cycles: no timeout, byte held steady
        do_reset();
        out_ready = 1'b1;
        req_valid = 3'b001;
        req_last  = 3'b001;
        req_data  = 24'h00005A;
        #2;
        chk("s38_idle", 32'(busy), 0);
        tick();
        out_ready = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (!(busy && grant_id == 2'd0 && out_valid && out_data == 8'h5A && req_ready == 3'b000))
                bad++;
            tick();
        end
        chk("s38_hold", bad, 0);
        out_ready = 1'b1;
        #2;
        chk("s38_xfer", 32'({out_valid, req_ready}), 32'b1001);
        tick();
        req_valid = 3'b000;
        #2;
        chk("s38_done", 32'(busy), 0);

        // Reset mid-packet from req1 after req0 held the previous grant
        do_reset();
        out_ready = 1'b1;
        req_valid = 3'b001;
        req_last  = 3'b001;
        req_data  = {8'hC2, 8'h88, 8'h77};
        tick();
        tick();
        req_valid = 3'b010;
        req_last  = 3'b000;
        tick();
        tick();
        #2;
        chk("s39_pre", 32'({busy, grant_id}), 32'b101);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("s39_async_busy", 32'(busy), 0);
        chk("s39_async_ovalid", 32'(out_valid), 0);
        chk("s39_async_ready", 32'(req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        req_valid = 3'b011;
        req_last  = 3'b011;
        #2;
        chk("s39_idle", 32'(busy), 0);
        tick();
        #2;
        chk("s39_first", 32'({busy, grant_id}), 32'b100);

        // Random packets, gaps, pauses and back-pressure against the model
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 8; p++) begin
                int len;
                len = $urandom_range(6, 1);
                for (int b = 0; b < len; b++) srcq[i].push_back({b == len - 1, 8'($urandom)});
            end
        end
        src_mode = 1'b1;
        rnd_gaps = 1'b1;
        rnd_ordy = 1'b1;
        drive_srcs();
        cyc = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() > 0 || busy) && cyc < 4000) begin
            tick();
            cyc++;
        end
        chk("rnd_drain", srcq[0].size() + srcq[1].size() + srcq[2].size(), 0);
        src_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of requesters (legal range 2..4).
REQ-002 Parameter MAX_PKT, default 64, SHALL set the maximum bytes per grant before forced release (legal range 1..255).
REQ-003 Parameter IDLE_TMO, default 16, SHALL set the number of consecutive stalled cycles before forced release (legal range 1..255).
REQ-004 Port clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port req_valid  input  NUM_REQ  SHALL carry per-requester byte-valid.
REQ-007 Port req_last  input  NUM_REQ  SHALL mark the final byte of a requester packet; it is qualified by req_valid.
REQ-008 Port req_data  input  8*NUM_REQ  SHALL carry per-requester bytes; requester i occupies bits [8i+7:8i].
REQ-009 Port req_ready  output  NUM_REQ  SHALL carry per-requester accept.
REQ-010 Port out_valid  output  1  SHALL be the byte-valid toward the UART TX controller.
REQ-011 Port out_ready  input  1  SHALL be the accept from the UART TX controller.
REQ-012 Port out_data  output  8  SHALL be the byte toward the UART TX controller.
REQ-013 Port grant_id  output  2  SHALL give the index of the current grant holder; it is meaningful only while busy=1.
REQ-014 Port busy  output  1  SHALL be high while a grant is held.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and LOCK.
REQ-016 In IDLE, all req_ready bits and out_valid SHALL be 0.
REQ-017 Arbitration in IDLE SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, and the first requester with req_valid=1 wins.
REQ-018 When a winner exists in IDLE, the next state SHALL be LOCK, with grant_id set to the winner, busy set to 1, byte_cnt cleared and stall_cnt cleared.
REQ-019 Arbitration latency SHALL be one cycle; the first transfer is possible in the first LOCK cycle.
REQ-020 In LOCK, out_valid SHALL equal req_valid[grant_id], out_data SHALL equal the grant_id byte, and req_ready[grant_id] SHALL equal out_ready, all combinationally.
REQ-021 In LOCK, req_ready of every non-granted requester SHALL be 0.
REQ-022 A transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; the block SHALL never drop or duplicate a byte.
REQ-023 On each transfer, byte_cnt (8-bit) SHALL increment by 1 and stall_cnt SHALL clear.
REQ-024 In LOCK, each cycle with req_valid[grant_id]=0 SHALL increment stall_cnt (8-bit, saturating); cycles with valid=1 and ready=0 SHALL NOT count.
REQ-025 LOCK SHALL return to IDLE on the cycle after any one of these events:
  - a transfer with req_last[grant_id]=1;
  - a transfer that makes byte_cnt equal MAX_PKT;
  - stall_cnt reaching IDLE_TMO.
REQ-026 On any LOCK-to-IDLE exit, last_grant SHALL be set to grant_id and busy SHALL clear.
REQ-027 Precedence when exit events coincide: last, then MAX_PKT, then timeout. The outcome SHALL be identical regardless of which event fires.
REQ-028 Only one requester SHALL be granted at a time; with a single active requester, re-grant to the same requester SHALL be allowed after one IDLE cycle.
REQ-029 Changes to req_valid of non-granted requesters during LOCK SHALL have no effect until the next IDLE.
REQ-030 The data path SHALL add no bubble beyond the one IDLE cycle between grants.

Reset
REQ-031 While rst_n=0, the block SHALL hold these values: state=IDLE, last_grant=NUM_REQ-1, grant_id=0, busy=0, byte_cnt=0, stall_cnt=0, req_ready=0, out_valid=0.
REQ-032 Reset assertion mid-packet SHALL abort the grant immediately and asynchronously; no partial transfer is completed.
REQ-033 Deassertion SHALL be synchronised externally; the first post-reset grant SHALL go to requester 0 if it is valid.

Verification
REQ-034 Scenario: req0 sends a 3-byte packet (0x41, 0x42, 0x43 with last) and out_ready=1 throughout -> 1 IDLE cycle, then 3 consecutive transfers with grant_id=0, then busy=0.
REQ-035 Scenario: req0, req1 and req2 all valid continuously with 1-byte packets -> grants in order 0,1,2,0,1,2, each separated by one IDLE cycle.
REQ-036 Scenario: MAX_PKT=4, req1 streams 10 bytes without last and req2 is valid -> grant 1 for 4 bytes, grant 2 next, then grant 1 resumes at byte 5 with no byte lost.
REQ-037 Scenario: IDLE_TMO=16, req0 granted then drops valid for 16 cycles while req1 is valid -> release after the 16th stalled cycle, then grant_id=1.
REQ-038 Scenario: out_ready held 0 for 20 cycles during a packet -> no timeout, out_data stable, transfer completes when out_ready rises.
REQ-039 Scenario: rst_n pulsed low mid-packet -> outputs take reset values without waiting for a clock edge, and after release req0 wins first arbitration.
